// File: rtl/lcs_frame_seq_if.sv
// Bus between the LCS frame sequencer, the frame timer, the LCS answer
// block and the UART byte transmitter. The master side is the sequencer.
interface lcs_frame_seq_if;
    logic       start;
    logic       edgeTx;
    logic       ack;
    logic       txBusy;
    logic       req;
    logic [8:0] addrLCS;
    logic       txLoad;
    logic       busy;
    logic       frameDone;
    logic       errTimeout;
    logic [7:0] errCnt;

    modport master (
        input  start, edgeTx, ack, txBusy,
        output req, addrLCS, txLoad, busy, frameDone, errTimeout, errCnt
    );

    modport slave (
        output start, edgeTx, ack, txBusy,
        input  req, addrLCS, txLoad, busy, frameDone, errTimeout, errCnt
    );
endinterface

// File: rtl/lcs_frame_seq.sv
// LCS frame sequencer: walks word addresses 0..FRAME_WORDS-1 once per frame
// start, runs a four-phase req/ack handshake per word with the answer block,
// hands each acknowledged word to the UART, and reports ack timeouts.
module lcs_frame_seq #(
    parameter int FRAME_WORDS = 512,
    parameter int ACK_TIMEOUT = 255,
    parameter int GAP_EDGES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    lcs_frame_seq_if.master  bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] ACKHI = 3'd2;
    localparam logic [2:0] LOAD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;
    localparam logic [2:0] TOUT  = 3'd5;

    localparam logic [8:0] LAST_ADDR = 9'(FRAME_WORDS - 1);
    localparam logic [7:0] TO_LIMIT  = 8'(ACK_TIMEOUT);
    localparam logic [3:0] GAP_LIMIT = 4'(GAP_EDGES);

    logic [2:0] state;
    logic       ackMeta;
    logic       ackS;
    logic [7:0] toCnt;
    logic [3:0] gapCnt;
    logic       reqQ;
    logic [8:0] addrQ;
    logic       busyQ;
    logic       frameDoneQ;
    logic       errTimeoutQ;
    logic [7:0] errCntQ;

    logic toExpired;
    logic enterTout;
    logic gapDone;

    // The timeout counter restarts on entry to REQ and ACKHI, so reaching the
    // limit means the current wait state has lasted ACK_TIMEOUT+1 cycles.
    assign toExpired = (toCnt == TO_LIMIT);
    assign enterTout = toExpired && (((state == REQ) && !ackS) ||
                                     ((state == ACKHI) && ackS));
    // GAP holds one extra cycle after the last strobe so the registered
    // frameDone pulse appears while the state is still GAP.
    assign gapDone   = (gapCnt == GAP_LIMIT);

    assign bus.req        = reqQ;
    assign bus.addrLCS    = addrQ;
    assign bus.txLoad     = (state == LOAD) && !bus.txBusy;
    assign bus.busy       = busyQ;
    assign bus.frameDone  = frameDoneQ;
    assign bus.errTimeout = errTimeoutQ;
    assign bus.errCnt     = errCntQ;

    // Two-flop synchroniser for the asynchronous ack from the answer block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ackMeta <= 1'b0;
            ackS    <= 1'b0;
        end else begin
            ackMeta <= bus.ack;
            ackS    <= ackMeta;
        end
    end

    // Per-word handshake sequencing, address walk and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            reqQ       <= 1'b0;
            addrQ      <= 9'd0;
            busyQ      <= 1'b0;
            frameDoneQ <= 1'b0;
            toCnt      <= 8'd0;
            gapCnt     <= 4'd0;
        end else begin
            frameDoneQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addrQ <= 9'd0;
                        busyQ <= 1'b1;
                        reqQ  <= 1'b1;
                        toCnt <= 8'd0;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (ackS) begin
                        toCnt <= 8'd0;
                        state <= ACKHI;
                    end else if (toExpired) begin
                        reqQ  <= 1'b0;
                        state <= TOUT;
                    end else begin
                        toCnt <= toCnt + 8'd1;
                    end
                end
                ACKHI: begin
                    if (!ackS) begin
                        toCnt <= 8'd0;
                        state <= LOAD;
                    end else if (toExpired) begin
                        reqQ  <= 1'b0;
                        state <= TOUT;
                    end else begin
                        toCnt <= toCnt + 8'd1;
                    end
                end
                LOAD: begin
                    if (!bus.txBusy) begin
                        reqQ   <= 1'b0;
                        gapCnt <= 4'd0;
                        state  <= GAP;
                    end
                end
                TOUT: begin
                    gapCnt <= 4'd0;
                    state  <= GAP;
                end
                GAP: begin
                    if (gapDone) begin
                        if (addrQ == LAST_ADDR) begin
                            addrQ <= 9'd0;
                            state <= IDLE;
                        end else begin
                            addrQ <= addrQ + 9'd1;
                            reqQ  <= 1'b1;
                            toCnt <= 8'd0;
                            state <= REQ;
                        end
                    end else if (bus.edgeTx) begin
                        gapCnt <= gapCnt + 4'd1;
                        if ((addrQ == LAST_ADDR) && (gapCnt == GAP_LIMIT - 4'd1)) begin
                            busyQ      <= 1'b0;
                            frameDoneQ <= 1'b1;
                        end
                    end
                end
                default: begin
                    reqQ  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Timeout reporting: one pulse per skipped word and a saturating tally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            errTimeoutQ <= 1'b0;
            errCntQ     <= 8'd0;
        end else begin
            errTimeoutQ <= enterTout;
            if (enterTout && (errCntQ != 8'hFF)) begin
                errCntQ <= errCntQ + 8'd1;
            end
        end
    end

endmodule

// File: doc/lcs_frame_seq.md
# lcs_frame_seq

Frame sequencer for the LCS answer path. On each frame start it walks word addresses 0..FRAME_WORDS-1 and runs a four-phase req/ack handshake with the LCS answer block for each word. Once that block has acknowledged and released ack, it hands the word to the byte transmitter. It sits between the frame timer and the answer block plus the UART transmitter. It owns `addrLCS`, `req` and the transmit-load strobe, and it reports ack timeouts.

## Interface
- FRAME_WORDS, 512: words per frame; addresses 0..FRAME_WORDS-1, at most 512.
- ACK_TIMEOUT, 255: clk cycles allowed in each ack-wait state; range 1..255.
- GAP_EDGES, 2: `edgeTx` strobes with req low between words; range 1..15.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle frame start pulse; ignored unless idle.
- edgeTx  in  1  byte-slot strobe, one clk wide, synchronous to clk.
- ack  in  1  acknowledge from the answer block, asynchronous; 2-flop synchronised inside.
- txBusy  in  1  UART transmitter busy.
- req  out  1  request to the answer block.
- addrLCS  out  9  word address; stable whenever req=1.
- txLoad  out  1  one-cycle pulse telling the UART to load the current data byte.
- busy  out  1  high from frame accept until frameDone.
- frameDone  out  1  one-cycle pulse after the last word.
- errTimeout  out  1  one-cycle pulse per ack timeout.
- errCnt  out  8  saturating timeout count; cleared only by reset.

## Operation
- Reset (rst=0 at a clk edge) forces the following, from any state including mid-handshake:
  - state IDLE; req=0, addrLCS=0, txLoad=0, busy=0, frameDone=0, errTimeout=0, errCnt=0;
  - timeout and gap counters 0; ack synchroniser flops 0.
- `ackS` is the synchronised ack (second flop).
- States:
  - IDLE: on start=1, set addrLCS=0 and busy=1 -> REQ.
  - REQ: req=1. On ackS=1 -> ACKHI and clear the timeout counter. If the counter reaches ACK_TIMEOUT first -> TOUT.
  - ACKHI: req=1, wait for ackS=0. On ackS=0 -> LOAD and clear the counter. If the counter reaches ACK_TIMEOUT -> TOUT.
  - LOAD: wait for txBusy=0. On txBusy=0, pulse txLoad for one cycle, drop req -> GAP. No timeout in this state.
  - TOUT: req=0, one-cycle errTimeout pulse, errCnt += 1 (saturates at 255). The word is skipped -> GAP.
  - GAP: req=0. Count edgeTx strobes up to GAP_EDGES, then:
    - if addrLCS = FRAME_WORDS-1: set addrLCS=0, busy=0, pulse frameDone -> IDLE;
    - otherwise addrLCS += 1 -> REQ.
- start is ignored in every state except IDLE.
- A start in the same cycle as frameDone is ignored, because the state is still GAP in that cycle.
- edgeTx strobes outside GAP are ignored. In GAP, a strobe arriving on the GAP-entry cycle counts.
- addrLCS changes only in GAP/IDLE transitions, never while req=1.
- If ack is already high on entry to REQ (a stale ack), it is accepted as the acknowledge. Verification checks this case explicitly.

## Timing
- start at cycle n -> req=1 and busy=1 visible at n+1.
- ack rising at cycle m -> ackS=1 at m+2 -> state ACKHI at m+3.
- The ack falling edge follows the same latency: LOAD entered 3 cycles after ack falls.
- txLoad is asserted in the cycle LOAD sees txBusy=0. req is low from the following cycle.
- Timeout is measured in clk cycles, counted from state entry. With ack held low, errTimeout pulses ACK_TIMEOUT+1 cycles after REQ entry.
- Per-word minimum latency: 1 (REQ) + 3 (ack rise) + 3 (ack fall) + 1 (LOAD) + the GAP strobe wait.
- frameDone is registered and coincides with busy falling.

## Test plan
- Nominal frame, FRAME_WORDS=4, ack responder raising 2 cycles after req and dropping 5 cycles later, txBusy=0, edgeTx every 8 cycles -> required:
  - 4 txLoad pulses at addrLCS 0,1,2,3;
  - frameDone exactly once; busy low afterwards; errCnt=0.
- Ack stuck low, ACK_TIMEOUT=10, FRAME_WORDS=3 -> required:
  - three errTimeout pulses, each 11 cycles after its REQ entry; errCnt=3;
  - no txLoad; frameDone still pulses.
- Back-pressure: txBusy held high for 20 cycles at word 1 -> required: txLoad for word 1 delayed until txBusy falls; req stays high until then; addrLCS stays 1.
- start pulses at busy=1 and in the frameDone cycle -> required: no restart; state sequence unchanged; exactly one frame per accepted start.
- Reset driven low while in ACKHI at addrLCS=5 -> required: next cycle req=0, addrLCS=0, busy=0, errCnt=0; a following start begins at address 0.
- errCnt saturation with 300 forced timeouts -> required: errCnt holds at 255; errTimeout still pulses for every timeout.
